// File: rtl/imem_pkg.sv
// imem_pkg: shared types and defaults for the instruction fetch controller.
//   state_t          - fetch FSM state encoding (RUN / STALL / FLUSH)
//   OPC_*_DEF        - default decoded operation-type codes for jumps
//   NOP_FILL         - fill bit of the all-NOP (end of program) word
//   BUBBLE_FILL      - fill bit of the word driven to pc_if during a flush
//   ram_lat_ok()     - legal ins_ram latency range check (1..2)
package imem_pkg;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  localparam int unsigned OPC_JMP_DEF = 16;
  localparam int unsigned OPC_JNZ_DEF = 17;
  localparam int unsigned COND_AT_DEF = 3;

  localparam logic NOP_FILL    = 1'b1;
  localparam logic BUBBLE_FILL = 1'b0;

  localparam int unsigned RAM_LAT_MIN = 1;
  localparam int unsigned RAM_LAT_MAX = 2;

  function automatic bit ram_lat_ok(input int unsigned lat);
    return (lat >= RAM_LAT_MIN) && (lat <= RAM_LAT_MAX);
  endfunction

endpackage

// File: rtl/imem_stall_timer.sv
// imem_stall_timer: stall countdown used by the fetch FSM.
//   clk, reset   - clock, synchronous active-high reset
//   i_clr        - force count to zero (highest priority)
//   i_load       - load i_load_val
//   i_dec        - decrement, saturating at zero
//   o_count      - current count
//   o_zero       - count == 0
module imem_stall_timer #(
  parameter int unsigned DLY_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [DLY_W-1:0] i_load_val,
  input  logic             i_dec,
  output logic [DLY_W-1:0] o_count,
  output logic             o_zero
);

  logic [DLY_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_count = r_count;
  assign o_zero  = (r_count == '0);

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: fetch controller between pc_if and ins_ram.
//   clk, reset                       - clock, synchronous active-high reset
//   t_cs                             - core chip-select; low holds all state
//   ipt_pcif_en_b, ipt_pcif_addr     - fetch request from pc_if
//   opt_iram_en_b, opt_iram_addr     - registered request to ins_ram
//   ipt_iram_dat                     - ins_ram read data
//   opt_pcif_dat                     - pipelined word, bubble while flushing
//   opt_pcif_lockrq                  - hold pc_if
//   opt_pcif_jmp_sel/_addr           - redirect strobe and target
//   ipt_dec_*                        - decoder op type, stall and jump request
//   ipt_alu_jmp_sel                  - JNZ condition
//   ipt_alu_done                     - ALU completion, aborts a stall
module imem_fetch_ctrl
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned INS_W   = 32,
  parameter int unsigned DST_W   = 10,
  parameter int unsigned OPR_W   = 5,
  parameter int unsigned DLY_W   = 4,
  parameter int unsigned RAM_LAT = 1,
  parameter logic [OPR_W-1:0] OPC_JMP = OPR_W'(OPC_JMP_DEF),
  parameter logic [OPR_W-1:0] OPC_JNZ = OPR_W'(OPC_JNZ_DEF),
  parameter logic [DLY_W-1:0] COND_AT = DLY_W'(COND_AT_DEF),
  parameter logic [INS_W-1:0] NOP_WORD    = {INS_W{NOP_FILL}},
  parameter logic [INS_W-1:0] BUBBLE_WORD = {INS_W{BUBBLE_FILL}}
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              t_cs,
  input  logic              ipt_pcif_en_b,
  input  logic [ADDR_W-1:0] ipt_pcif_addr,
  output logic              opt_iram_en_b,
  output logic [ADDR_W-1:0] opt_iram_addr,
  input  logic [INS_W-1:0]  ipt_iram_dat,
  output logic [INS_W-1:0]  opt_pcif_dat,
  output logic              opt_pcif_lockrq,
  output logic              opt_pcif_jmp_sel,
  output logic [DST_W-1:0]  opt_pcif_jmp_addr,
  input  logic [OPR_W-1:0]  ipt_dec_opr_typ,
  input  logic [DLY_W-1:0]  ipt_dec_delay,
  input  logic              ipt_dec_delay_sel,
  input  logic              ipt_dec_jmp_sel,
  input  logic [DST_W-1:0]  ipt_dec_jmp_addr,
  input  logic              ipt_alu_jmp_sel,
  input  logic              ipt_alu_done
);

  if (!ram_lat_ok(RAM_LAT)) begin : g_bad_ram_lat
    $error("imem_fetch_ctrl: RAM_LAT must be 1 or 2");
  end

  // Fetch request registers
  logic              r_en_b;
  logic [ADDR_W-1:0] r_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_en_b <= 1'b1;
      r_addr <= '0;
    end else if (t_cs) begin
      r_en_b <= ipt_pcif_en_b;
      r_addr <= ipt_pcif_addr;
    end
  end

  assign opt_iram_en_b = r_en_b;
  assign opt_iram_addr = r_addr;

  // Instruction data pipeline, one stage per cycle of RAM latency
  logic [INS_W-1:0] r_dat [RAM_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < RAM_LAT; i++) begin
        r_dat[i] <= '0;
      end
    end else if (t_cs) begin
      r_dat[0] <= ipt_iram_dat;
      for (int unsigned i = 1; i < RAM_LAT; i++) begin
        r_dat[i] <= r_dat[i-1];
      end
    end
  end

  // Jump request registers
  logic             r_jmp_sel;
  logic [DST_W-1:0] r_jmp_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_jmp_sel  <= 1'b0;
      r_jmp_addr <= '0;
    end else if (t_cs) begin
      r_jmp_sel  <= ipt_dec_jmp_sel;
      r_jmp_addr <= ipt_dec_jmp_addr;
    end
  end

  assign opt_pcif_jmp_addr = r_jmp_addr;

  // Stall timer and its control
  state_t           r_state;
  logic [1:0]       r_flush_cnt;
  logic [DLY_W-1:0] w_timer;
  logic             w_tmr_zero;
  logic             w_tmr_last;
  logic             w_take;
  logic             w_load;
  logic             w_clr;
  logic             w_dec;

  always_comb begin
    w_take = 1'b0;
    if (r_state == ST_STALL) begin
      if ((ipt_dec_opr_typ == OPC_JMP) && (w_timer == ipt_dec_delay) && r_jmp_sel) begin
        w_take = 1'b1;
      end else if ((ipt_dec_opr_typ == OPC_JNZ) && (w_timer == COND_AT) && ipt_alu_jmp_sel) begin
        w_take = 1'b1;
      end
    end
  end

  // Timer control mirrors the FSM priority: alu_done, t_cs hold, take, load, decrement
  assign w_clr  = ipt_alu_done | (t_cs & w_take);
  assign w_load = ~ipt_alu_done & t_cs & ~w_take & ipt_dec_delay_sel & (ipt_dec_delay != '0);
  assign w_dec  = ~ipt_alu_done & t_cs & ~w_take & ~w_load & (r_state == ST_STALL);

  imem_stall_timer #(
    .DLY_W (DLY_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .i_clr      (w_clr),
    .i_load     (w_load),
    .i_load_val (ipt_dec_delay),
    .i_dec      (w_dec),
    .o_count    (w_timer),
    .o_zero     (w_tmr_zero)
  );

  // The decrement that reaches zero (or a saturated zero) ends the stall
  assign w_tmr_last = w_tmr_zero | (w_timer == DLY_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else if (ipt_alu_done) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= '0;
    end else if (t_cs) begin
      if (w_take) begin
        r_state     <= ST_FLUSH;
        r_flush_cnt <= 2'(RAM_LAT);
      end else if (w_load) begin
        r_state <= ST_STALL;
      end else begin
        case (r_state)
          ST_STALL: begin
            if (w_tmr_last) begin
              r_state <= ST_RUN;
            end
          end
          ST_FLUSH: begin
            // Counter starts at RAM_LAT, so leaving on the 1->0 step gives RAM_LAT flush cycles
            r_flush_cnt <= r_flush_cnt - 1'b1;
            if (r_flush_cnt <= 2'd1) begin
              r_state <= ST_RUN;
            end
          end
          default: r_state <= ST_RUN;
        endcase
      end
    end
  end

  assign opt_pcif_jmp_sel = w_take;
  assign opt_pcif_lockrq  = (ipt_iram_dat == NOP_WORD) ? 1'b1 : (r_state != ST_RUN);
  assign opt_pcif_dat     = (r_state == ST_FLUSH) ? BUBBLE_WORD : r_dat[RAM_LAT-1];

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

  localparam int S_LOCK = 0;
  localparam int S_JSEL = 1;
  localparam int S_ENB  = 2;
  localparam int S_ADDR = 3;
  localparam int S_DAT  = 4;
  localparam int S_TMR  = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        t_cs;
  logic        ipt_pcif_en_b;
  logic [9:0]  ipt_pcif_addr;
  logic        opt_iram_en_b;
  logic [9:0]  opt_iram_addr;
  logic [31:0] ipt_iram_dat;
  logic [31:0] opt_pcif_dat;
  logic        opt_pcif_lockrq;
  logic        opt_pcif_jmp_sel;
  logic [9:0]  opt_pcif_jmp_addr;
  logic [4:0]  ipt_dec_opr_typ;
  logic [3:0]  ipt_dec_delay;
  logic        ipt_dec_delay_sel;
  logic        ipt_dec_jmp_sel;
  logic [9:0]  ipt_dec_jmp_addr;
  logic        ipt_alu_jmp_sel;
  logic        ipt_alu_done;

  imem_fetch_ctrl #(
    .RAM_LAT (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .t_cs              (t_cs),
    .ipt_pcif_en_b     (ipt_pcif_en_b),
    .ipt_pcif_addr     (ipt_pcif_addr),
    .opt_iram_en_b     (opt_iram_en_b),
    .opt_iram_addr     (opt_iram_addr),
    .ipt_iram_dat      (ipt_iram_dat),
    .opt_pcif_dat      (opt_pcif_dat),
    .opt_pcif_lockrq   (opt_pcif_lockrq),
    .opt_pcif_jmp_sel  (opt_pcif_jmp_sel),
    .opt_pcif_jmp_addr (opt_pcif_jmp_addr),
    .ipt_dec_opr_typ   (ipt_dec_opr_typ),
    .ipt_dec_delay     (ipt_dec_delay),
    .ipt_dec_delay_sel (ipt_dec_delay_sel),
    .ipt_dec_jmp_sel   (ipt_dec_jmp_sel),
    .ipt_dec_jmp_addr  (ipt_dec_jmp_addr),
    .ipt_alu_jmp_sel   (ipt_alu_jmp_sel),
    .ipt_alu_done      (ipt_alu_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] addr;
  } jmp_t;

  exp_t exp_q[$];
  jmp_t jq[$];

  function automatic logic [31:0] probe(input int sig);
    case (sig)
      S_LOCK:  return 32'(opt_pcif_lockrq);
      S_JSEL:  return 32'(opt_pcif_jmp_sel);
      S_ENB:   return 32'(opt_iram_en_b);
      S_ADDR:  return 32'(opt_iram_addr);
      S_DAT:   return opt_pcif_dat;
      default: return 32'(dut.w_timer);
    endcase
  endfunction

  task automatic exp_at(input int d, input int sig, input logic [31:0] v, input string nm);
    exp_t e;
    e.cyc  = cyc + d;
    e.sig  = sig;
    e.val  = v;
    e.name = nm;
    exp_q.push_back(e);
  endtask

  task automatic exp_lock(input int d0, input int d1, input logic v, input string nm);
    for (int d = d0; d <= d1; d++) exp_at(d, S_LOCK, 32'(v), nm);
  endtask

  task automatic push_jmp(input int d, input logic [31:0] a);
    jmp_t j;
    j.cyc  = cyc + d;
    j.addr = a;
    jq.push_back(j);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares scheduled expectations and every redirect pulse the DUT presents
  always @(negedge clk) begin
    logic [31:0] act;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      if (exp_q[i].cyc == cyc) begin
        act   = probe(exp_q[i].sig);
        total = total + 1;
        if (act !== exp_q[i].val) begin
          bad = bad + 1;
          $display("FAIL %s cyc=%0d actual=%0h required=%0h", exp_q[i].name, cyc, act, exp_q[i].val);
        end
        exp_q.delete(i);
      end
    end
    if (opt_pcif_jmp_sel === 1'b1) begin
      total = total + 1;
      if (jq.size() == 0) begin
        bad = bad + 1;
        $display("FAIL unexpected_jmp cyc=%0d actual=1 required=0 addr=%0h", cyc, opt_pcif_jmp_addr);
      end else begin
        jmp_t j;
        j = jq.pop_front();
        if ((j.cyc != cyc) || (32'(opt_pcif_jmp_addr) !== j.addr)) begin
          bad = bad + 1;
          $display("FAIL jmp_pulse actual cyc=%0d addr=%0h required cyc=%0d addr=%0h",
                   cyc, opt_pcif_jmp_addr, j.cyc, j.addr);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset             = 1'b1;
    t_cs              = 1'b1;
    ipt_pcif_en_b     = 1'b1;
    ipt_pcif_addr     = '0;
    ipt_iram_dat      = 32'h1234_5678;
    ipt_dec_opr_typ   = '0;
    ipt_dec_delay     = '0;
    ipt_dec_delay_sel = 1'b0;
    ipt_dec_jmp_sel   = 1'b0;
    ipt_dec_jmp_addr  = '0;
    ipt_alu_jmp_sel   = 1'b0;
    ipt_alu_done      = 1'b0;
    step(2);
    reset = 1'b0;

    // Reset state and data latency
    exp_at(0, S_ENB,  1, "rst_en_b");
    exp_at(0, S_JSEL, 0, "rst_jmp_sel");
    exp_at(0, S_LOCK, 0, "rst_lockrq");
    exp_at(0, S_ADDR, 0, "rst_addr");
    exp_at(0, S_DAT,  0, "rst_dat");
    exp_at(1, S_DAT,  0, "rst_dat_stage");
    exp_at(2, S_DAT,  32'h1234_5678, "dat_latency");
    step(1);

    // Fetch address and new data word
    ipt_pcif_en_b = 1'b0;
    ipt_pcif_addr = 10'h005;
    ipt_iram_dat  = 32'hCAFE_F00D;
    exp_at(1, S_ADDR, 5, "iram_addr");
    exp_at(1, S_ENB,  0, "iram_en_b");
    exp_at(1, S_DAT,  32'h1234_5678, "dat_old");
    exp_at(2, S_DAT,  32'hCAFE_F00D, "dat_new");
    step(4);

    // Stall of 4 with t_cs high
    ipt_dec_delay = 4'd4; ipt_dec_delay_sel = 1'b1;
    exp_lock(0, 0, 0, "stall4_pre");
    exp_lock(1, 4, 1, "stall4_lock");
    exp_lock(5, 5, 0, "stall4_end");
    step(1);
    ipt_dec_delay = '0; ipt_dec_delay_sel = 1'b0;
    step(6);

    // Stall of 4 with two t_cs-low cycles inside
    ipt_dec_delay = 4'd4; ipt_dec_delay_sel = 1'b1;
    exp_lock(1, 6, 1, "stall4cs_lock");
    exp_lock(7, 7, 0, "stall4cs_end");
    step(1);
    ipt_dec_delay = '0; ipt_dec_delay_sel = 1'b0;
    step(1);
    t_cs = 1'b0;
    step(2);
    t_cs = 1'b1;
    step(5);

    // Unconditional jump: delay 3, target 0x2A
    ipt_dec_opr_typ = 5'd16; ipt_dec_delay = 4'd3; ipt_dec_delay_sel = 1'b1;
    ipt_dec_jmp_sel = 1'b1;  ipt_dec_jmp_addr = 10'h02A;
    push_jmp(1, 32'h2A);
    exp_at(0, S_JSEL, 0, "jmp_not_in_run");
    exp_at(2, S_JSEL, 0, "jmp_one_cycle");
    exp_lock(1, 3, 1, "jmp_lock");
    exp_lock(4, 4, 0, "jmp_lock_end");
    exp_at(2, S_DAT, 0, "jmp_bubble0");
    exp_at(3, S_DAT, 0, "jmp_bubble1");
    exp_at(4, S_DAT, 32'hCAFE_F00D, "jmp_post_dat");
    step(1);
    ipt_dec_delay_sel = 1'b0; ipt_dec_jmp_sel = 1'b0;
    step(1);
    ipt_dec_opr_typ = '0; ipt_dec_delay = '0;
    step(4);

    // Conditional jump taken at timer 3
    ipt_dec_opr_typ = 5'd17; ipt_dec_delay = 4'd5; ipt_dec_delay_sel = 1'b1;
    ipt_alu_jmp_sel = 1'b1;  ipt_dec_jmp_addr = 10'h155;
    push_jmp(3, 32'h155);
    exp_at(2, S_JSEL, 0, "jnz_not_at4");
    exp_lock(1, 5, 1, "jnz_lock");
    exp_lock(6, 6, 0, "jnz_lock_end");
    exp_at(4, S_DAT, 0, "jnz_bubble0");
    exp_at(5, S_DAT, 0, "jnz_bubble1");
    step(1);
    ipt_dec_delay_sel = 1'b0;
    step(5);
    ipt_dec_opr_typ = '0; ipt_alu_jmp_sel = 1'b0; ipt_dec_delay = '0;
    step(2);

    // Conditional jump not taken: full stall
    ipt_dec_opr_typ = 5'd17; ipt_dec_delay = 4'd5; ipt_dec_delay_sel = 1'b1;
    exp_lock(1, 5, 1, "jnz_nt_lock");
    exp_lock(6, 6, 0, "jnz_nt_end");
    step(1);
    ipt_dec_delay_sel = 1'b0;
    step(6);
    ipt_dec_opr_typ = '0; ipt_dec_delay = '0;
    step(1);

    // alu_done aborts a stall of 8
    ipt_dec_delay = 4'd8; ipt_dec_delay_sel = 1'b1;
    exp_lock(1, 2, 1, "abort_lock");
    exp_at(2, S_TMR, 7, "abort_timer_dec");
    exp_lock(3, 4, 0, "abort_lock_end");
    exp_at(3, S_TMR, 0, "abort_timer");
    step(1);
    ipt_dec_delay = '0; ipt_dec_delay_sel = 1'b0;
    step(1);
    ipt_alu_done = 1'b1;
    step(1);
    ipt_alu_done = 1'b0;
    step(2);

    // alu_done together with delay_sel
    ipt_alu_done = 1'b1; ipt_dec_delay = 4'd4; ipt_dec_delay_sel = 1'b1;
    exp_lock(0, 2, 0, "done_sel_lock");
    exp_at(1, S_TMR, 0, "done_sel_timer");
    step(1);
    ipt_alu_done = 1'b0; ipt_dec_delay = '0; ipt_dec_delay_sel = 1'b0;
    step(2);

    // alu_done together with a taken jump: pulse visible, no flush
    ipt_dec_opr_typ = 5'd16; ipt_dec_delay = 4'd2; ipt_dec_delay_sel = 1'b1;
    ipt_dec_jmp_sel = 1'b1;  ipt_dec_jmp_addr = 10'h0F0;
    push_jmp(1, 32'h0F0);
    exp_lock(1, 1, 1, "done_take_lock");
    exp_lock(2, 3, 0, "done_take_run");
    exp_at(2, S_DAT, 32'hCAFE_F00D, "done_take_nobubble");
    step(1);
    ipt_dec_delay_sel = 1'b0; ipt_dec_jmp_sel = 1'b0; ipt_alu_done = 1'b1;
    step(1);
    ipt_alu_done = 1'b0; ipt_dec_opr_typ = '0; ipt_dec_delay = '0;
    step(2);

    // End-of-program NOP word holds the lock in RUN
    ipt_iram_dat = 32'hFFFF_FFFF;
    exp_lock(0, 0, 1, "nop_lock");
    step(1);
    ipt_iram_dat = 32'hCAFE_F00D;
    exp_lock(0, 0, 0, "nop_release");
    step(3);

    // Stall of 1: timer saturates at 0 afterwards
    ipt_dec_delay = 4'd1; ipt_dec_delay_sel = 1'b1;
    exp_lock(1, 1, 1, "stall1_lock");
    exp_at(1, S_TMR, 1, "stall1_timer");
    exp_lock(2, 3, 0, "stall1_end");
    exp_at(2, S_TMR, 0, "sat_timer0");
    exp_at(3, S_TMR, 0, "sat_timer1");
    step(1);
    ipt_dec_delay = '0; ipt_dec_delay_sel = 1'b0;
    step(4);

    // Reset in the middle of a stall
    ipt_dec_delay = 4'd6; ipt_dec_delay_sel = 1'b1;
    exp_lock(1, 2, 1, "rst_mid_stall");
    step(1);
    ipt_dec_delay = '0; ipt_dec_delay_sel = 1'b0;
    step(1);
    reset = 1'b1;
    exp_lock(1, 1, 0, "rst_mid_lock");
    exp_at(1, S_TMR, 0, "rst_mid_timer");
    exp_at(1, S_ENB, 1, "rst_mid_en_b");
    exp_at(1, S_DAT, 0, "rst_mid_dat");
    step(1);
    reset = 1'b0;
    step(3);

    // Everything scheduled must have been checked
    total = total + 1;
    if (exp_q.size() != 0) begin
      bad = bad + 1;
      $display("FAIL pending_checks actual=%0d required=0", exp_q.size());
    end
    total = total + 1;
    if (jq.size() != 0) begin
      bad = bad + 1;
      $display("FAIL missing_jmp actual=%0d required=0", jq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Parametrised fetch controller between pc_if and ins_ram. It registers the fetch address and enable, and pipelines the instruction word over a configurable RAM latency. A three-state machine drives the pc_if lock request from a saturating stall timer and issues unconditional or conditional jump redirects. After a taken jump it squashes the in-flight fetch words with a bubble word.

## Interface
- ADDR_W, 10: instruction memory address width
- INS_W, 32: instruction word width
- DST_W, 10: jump target width
- OPR_W, 5: decoded operation-type width
- DLY_W, 4: delay/timer width
- RAM_LAT, 1: ins_ram read latency in cycles, 1 or 2; sets data pipeline depth and flush length
- OPC_JMP, 16 / OPC_JNZ, 17: operation-type codes
- COND_AT, 3: timer value at which a JNZ condition is sampled
- NOP_WORD, all ones: all-NOP instruction word that holds the lock (end of program)
- BUBBLE_WORD, 0: word driven to pc_if during a flush
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- t_cs  in  1  core chip-select; when low, all state holds (reset and alu_done still act)
- ipt_pcif_en_b, ipt_pcif_addr  in  1, ADDR_W  fetch enable (active low) and address from pc_if
- opt_iram_en_b, opt_iram_addr  out  1, ADDR_W  registered enable and address to ins_ram
- ipt_iram_dat  in  INS_W  ins_ram read data
- opt_pcif_dat  out  INS_W  pipelined instruction word, or BUBBLE_WORD while flushing
- opt_pcif_lockrq  out  1  1 = hold pc_if
- opt_pcif_jmp_sel, opt_pcif_jmp_addr  out  1, DST_W  redirect strobe and target
- ipt_dec_opr_typ  in  OPR_W  decoded operation type
- ipt_dec_delay, ipt_dec_delay_sel  in  DLY_W, 1  stall length and its load strobe
- ipt_dec_jmp_sel, ipt_dec_jmp_addr  in  1, DST_W  decoder jump request and target
- ipt_alu_jmp_sel  in  1  JNZ condition (nonzero)
- ipt_alu_done  in  1  multi-cycle ALU completion; aborts the stall

## Operation
- Fetch path: en_b and addr registers load when t_cs is high. The data path has RAM_LAT register stages, each loading when t_cs is high. opt_pcif_dat is the last stage, or BUBBLE_WORD when state = FLUSH.
- Jump registers: dec_jmp_sel and dec_jmp_addr are registered when t_cs is high. opt_pcif_jmp_addr is the registered target.
- States: RUN, STALL, FLUSH. The timer is DLY_W bits wide. The flush counter is 2 bits wide.
- Jump evaluation (combinational, only in STALL):
  - JMP: take = (opr == OPC_JMP) and (timer == ipt_dec_delay) and the registered jmp_sel.
  - JNZ: take = (opr == OPC_JNZ) and (timer == COND_AT) and ipt_alu_jmp_sel.
  - Otherwise take = 0.
  - opt_pcif_jmp_sel = take.
- Next-state priority, highest first:
  1. reset: state RUN, timer 0, flush counter 0.
  2. ipt_alu_done: state RUN, timer 0, regardless of t_cs.
  3. t_cs low: hold.
  4. take: state FLUSH, flush counter = RAM_LAT, timer 0.
  5. delay_sel with delay != 0: state STALL, timer = delay. This reloads in any state, including an in-progress STALL.
  6. STALL: timer decrements with saturation (never wraps). The cycle that makes it 0 returns to RUN.
  7. FLUSH: flush counter decrements. At 0, return to RUN.
- delay_sel with delay = 0 is a no-op in RUN.
- opt_pcif_lockrq = 1 if ipt_iram_dat == NOP_WORD, else (state != RUN).

## Timing
- Reset values: opt_iram_en_b = 1, opt_iram_addr = 0, data stages = 0, opt_pcif_jmp_addr = 0, opt_pcif_jmp_sel = 0.
- opt_pcif_lockrq after reset = (ipt_iram_dat == NOP_WORD).
- Address latency to ins_ram: 1 cycle. Data latency to pc_if: RAM_LAT cycles after ins_ram output.
- Stall of delay D starting in RUN: lockrq is high for exactly D t_cs-active cycles, beginning the cycle after the load.
- The jmp_sel pulse lasts exactly 1 cycle. It is followed by RAM_LAT FLUSH cycles with lockrq high and bubbles on opt_pcif_dat.
- alu_done in the same cycle as take or delay_sel: alu_done wins, no redirect state is entered, and jmp_sel is still visible combinationally.
- Reset mid-STALL or mid-FLUSH: state is RUN on the next cycle.

## Structure
- Package imem_pkg holds: the state enum, OPC_JMP/OPC_JNZ defaults, NOP_WORD and BUBBLE_WORD defaults, and a RAM_LAT range check (1..2).
- Sub-module imem_stall_timer provides load, saturating decrement and clear, with a zero flag.
- The FSM, fetch registers and data pipeline live in the top module.

## Test plan
- Reset, then release with ipt_iram_dat = 0x12345678: opt_iram_en_b = 1, jmp_sel = 0, lockrq = 0. Set addr = 0x05 with t_cs high: opt_iram_addr = 0x05 after 1 cycle.
- delay_sel with delay = 4 and t_cs held high: lockrq high for 4 cycles, then low. Repeat with t_cs low for 2 of those cycles: lockrq high for 6 cycles.
- JMP with delay = 3, dec_jmp_sel = 1, addr = 0x2A, RAM_LAT = 2: jmp_sel pulses 1 cycle after the load with jmp_addr = 0x2A. opt_pcif_dat = 0 for the next 2 cycles.
- JNZ with delay = 5 and ipt_alu_jmp_sel = 1: jmp_sel asserts only when timer = 3. Repeat with ipt_alu_jmp_sel = 0: no pulse, and the stall runs its full 5 cycles.
- delay = 8, then alu_done after 2 cycles: lockrq drops the next cycle and the timer reads 0. Assert alu_done together with delay_sel: the state stays RUN.
- ipt_iram_dat = NOP_WORD in RUN: lockrq = 1. Timer in STALL at 1 with an extra t_cs cycle: the timer reads 0, not all ones.
